// File: rtl/avr_sram_req_queue_if.sv
// Bundle of the request/response and memory-side signals of avr_sram_req_queue.
//   slave  : view taken by the queue itself (accepts requests, drives MEM_* request)
//   master : view taken by the surrounding logic (command decoder + master memory FSM)
// Signals:
//   REQ_VALID/REQ_READY/REQ_WRITE/REQ_ADDR/REQ_WDATA  upstream request handshake
//   RD_VALID/RD_DATA                                  read result back to the decoder
//   MEM_REQ/MEM_WRITE/MEM_ADDR/MEM_WDATA              head request to the master FSM
//   MEM_GRANT/MEM_RDATA/MEM_RDATA_VALID               AVR slot grant and read return
interface avr_sram_req_queue_if #(
  parameter int unsigned ADDR_W = 24
);
  logic              REQ_VALID;
  logic              REQ_READY;
  logic              REQ_WRITE;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic [7:0]        REQ_WDATA;
  logic              RD_VALID;
  logic [7:0]        RD_DATA;
  logic              MEM_REQ;
  logic              MEM_WRITE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [7:0]        MEM_WDATA;
  logic              MEM_GRANT;
  logic [7:0]        MEM_RDATA;
  logic              MEM_RDATA_VALID;

  modport slave (
    input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA,
    input  MEM_GRANT, MEM_RDATA, MEM_RDATA_VALID,
    output REQ_READY, RD_VALID, RD_DATA,
    output MEM_REQ, MEM_WRITE, MEM_ADDR, MEM_WDATA
  );

  modport master (
    output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA,
    output MEM_GRANT, MEM_RDATA, MEM_RDATA_VALID,
    input  REQ_READY, RD_VALID, RD_DATA,
    input  MEM_REQ, MEM_WRITE, MEM_ADDR, MEM_WDATA
  );
endinterface

// File: rtl/avr_sram_req_queue.sv
// Request queue between the AVR command decoder and the master memory FSM.
// Buffers SRAM read/write requests and issues them one at a time in the AVR
// slot granted once per SNES bus cycle; read data is returned to the decoder.
// With FORCE=1 the AVR owns the bus: grants are self-generated and reads are
// sampled a fixed FORCE_LAT cycles after the grant.
// Ports:
//   CLK      design clock (DCM CLKFX domain)
//   RESET_N  asynchronous active-low reset
//   bus      request / read-return / memory-slot signals (slave view)
//   FORCE    AVR owns the bus (self-grant, self-timed reads)
//   FLUSH    synchronous queue clear, abandons any pending read
//   COUNT    entries held, including the one being serviced
//   ERR      sticky read-timeout flag
//   ERR_CLR  clears ERR (a timeout in the same cycle wins)
module avr_sram_req_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned FORCE_LAT = 3,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  avr_sram_req_queue_if.slave    bus,
  input  logic                   FORCE,
  input  logic                   FLUSH,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   ERR,
  input  logic                   ERR_CLR
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESENT,
    ST_RD_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_mem  [DEPTH];
  logic [7:0]        wdata_mem [DEPTH];
  logic              write_mem [DEPTH];

  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              full, empty;
  logic              push, pop;

  logic              grant;
  logic              rd_sample;
  logic              rd_timeout;
  logic              load_head;
  logic              mem_req;

  logic              force_mode;
  logic [7:0]        wait_cnt;

  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              rd_valid_q;
  logic [7:0]        rd_data_q;
  logic              err_q;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // Readiness comes from the registered count only, so a pop in the same
  // cycle never lets a push into a full queue.
  assign push  = bus.REQ_VALID && !full && !FLUSH;

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (FLUSH) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!empty) state_nxt = ST_PRESENT;
        end
        ST_PRESENT: begin
          if (grant) state_nxt = mem_write_q ? ST_IDLE : ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (rd_sample || rd_timeout) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output / action decode. FLUSH suppresses every action so an abandoned
  // read never produces RD_VALID and nothing is popped twice.
  always_comb begin
    mem_req    = (state == ST_PRESENT);
    grant      = 1'b0;
    rd_sample  = 1'b0;
    rd_timeout = 1'b0;
    load_head  = 1'b0;
    pop        = 1'b0;
    if (!FLUSH) begin
      unique case (state)
        ST_IDLE: begin
          load_head = !empty;
        end
        ST_PRESENT: begin
          grant = FORCE ? 1'b1 : bus.MEM_GRANT;
          pop   = grant && mem_write_q;
        end
        ST_RD_WAIT: begin
          // The read completes under the mode latched at its grant.
          rd_sample  = force_mode ? (wait_cnt == 8'(FORCE_LAT - 1))
                                  : bus.MEM_RDATA_VALID;
          rd_timeout = !rd_sample && (wait_cnt == 8'(TIMEOUT - 1));
          pop        = rd_sample || rd_timeout;
        end
        default: ;
      endcase
    end
  end

  // Queue storage (no reset needed; validity is tracked by count)
  always_ff @(posedge CLK) begin
    if (push) begin
      addr_mem[wr_ptr]  <= bus.REQ_ADDR;
      wdata_mem[wr_ptr] <= bus.REQ_WDATA;
      write_mem[wr_ptr] <= bus.REQ_WRITE;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head request registers: captured on IDLE->PRESENT and held until the
  // entry is popped (including through RD_WAIT).
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (load_head) begin
      mem_write_q <= write_mem[rd_ptr];
      mem_addr_q  <= addr_mem[rd_ptr];
      mem_wdata_q <= wdata_mem[rd_ptr];
    end
  end

  // Read wait timing: counter restarts every PRESENT cycle, so it reads 0
  // in the first RD_WAIT cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      force_mode <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      if (grant) force_mode <= FORCE;
      if (state == ST_PRESENT) begin
        wait_cnt <= '0;
      end else if (state == ST_RD_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // Read return and error flag
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      if (rd_sample) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= bus.MEM_RDATA;
      end else if (rd_timeout) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= 8'hFF;
      end
      if (rd_timeout) begin
        err_q <= 1'b1;
      end else if (ERR_CLR) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus.REQ_READY = !full;
  assign bus.RD_VALID  = rd_valid_q;
  assign bus.RD_DATA   = rd_data_q;
  assign bus.MEM_REQ   = mem_req;
  assign bus.MEM_WRITE = mem_write_q;
  assign bus.MEM_ADDR  = mem_addr_q;
  assign bus.MEM_WDATA = mem_wdata_q;
  assign COUNT         = count;
  assign ERR           = err_q;

endmodule
